// File: rtl/rob_alloc_responder.sv
// rob_alloc_responder
//   Reorder buffer serving the dispatcher. Entries are allocated in program
//   order at the tail. The tag of the newest entry is returned one cycle after
//   the request. Results are captured from the ALU and LSB broadcast buses.
//   Ready entries retire in order from the head to the register file.
//
// Ports
//   clk, rst (async, active-low), rdy (0 = freeze all state)
//   Allocation   : ena_from_dsp, rd_from_dsp, data_from_dsp, pc_from_dsp
//                  -> rob_id_to_dsp (registered), full_to_dsp (registered)
//   Operand query: Q1/Q2_from_dsp -> Q1/Q2_ready_to_dsp, V1/V2_to_dsp
//                  (combinational, with writeback bypass)
//   Writeback    : ena/rob_id/data_from_alu, ena/rob_id/data_from_lsb
//   Commit       : ena_to_reg, rd_to_reg, Q_to_reg, V_to_reg (registered)
//
// Tags: entry index i is tag i+1, and tag 0 means "no dependency".
module rob_alloc_responder #(
  parameter int ROB_LEN  = 4,
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int REG_LEN  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                ena_from_dsp,
  input  logic [REG_LEN-1:0]  rd_from_dsp,
  input  logic [DATA_LEN-1:0] data_from_dsp,
  input  logic [ADDR_LEN-1:0] pc_from_dsp,
  output logic [ROB_LEN:0]    rob_id_to_dsp,
  input  logic [ROB_LEN:0]    Q1_from_dsp,
  input  logic [ROB_LEN:0]    Q2_from_dsp,
  output logic                Q1_ready_to_dsp,
  output logic                Q2_ready_to_dsp,
  output logic [DATA_LEN-1:0] V1_to_dsp,
  output logic [DATA_LEN-1:0] V2_to_dsp,
  input  logic                ena_from_alu,
  input  logic [ROB_LEN:0]    rob_id_from_alu,
  input  logic [DATA_LEN-1:0] data_from_alu,
  input  logic                ena_from_lsb,
  input  logic [ROB_LEN:0]    rob_id_from_lsb,
  input  logic [DATA_LEN-1:0] data_from_lsb,
  output logic                ena_to_reg,
  output logic [REG_LEN-1:0]  rd_to_reg,
  output logic [ROB_LEN:0]    Q_to_reg,
  output logic [DATA_LEN-1:0] V_to_reg,
  output logic                full_to_dsp
);

  localparam int DEPTH = 1 << ROB_LEN;
  localparam int TAG_W = ROB_LEN + 1;
  localparam logic [TAG_W-1:0] DEPTH_C   = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] ALMOST_C  = TAG_W'(DEPTH - 1);

  logic [ROB_LEN-1:0]  head_r;
  logic [ROB_LEN-1:0]  tail_r;
  logic [TAG_W-1:0]    count_r;
  logic [DEPTH-1:0]    busy_r;
  logic [DEPTH-1:0]    ready_r;
  logic [REG_LEN-1:0]  rd_r   [DEPTH];
  logic [DATA_LEN-1:0] data_r [DEPTH];
  logic [ADDR_LEN-1:0] pc_r   [DEPTH];

  logic                alloc_s;
  logic                commit_s;
  logic [TAG_W-1:0]    next_count_s;
  logic [DEPTH-1:0]    alu_hit_s;
  logic [DEPTH-1:0]    lsb_hit_s;
  logic [ROB_LEN-1:0]  q1_idx_s;
  logic [ROB_LEN-1:0]  q2_idx_s;
  // pc is kept per entry for debug visibility; nothing downstream consumes it.
  logic [ADDR_LEN-1:0] unused_head_pc_s;

  // Resolve an operand query: no dependency, bypass from a live writeback
  // (LSB wins over ALU), or stored result. Returns {ready, value}.
  function automatic logic [DATA_LEN:0] resolve_query(
    input logic [TAG_W-1:0]    q,
    input logic                stored_ready,
    input logic [DATA_LEN-1:0] stored_data,
    input logic                alu_en,
    input logic [TAG_W-1:0]    alu_tag,
    input logic [DATA_LEN-1:0] alu_data,
    input logic                lsb_en,
    input logic [TAG_W-1:0]    lsb_tag,
    input logic [DATA_LEN-1:0] lsb_data
  );
    logic [DATA_LEN:0] res;
    if (q == {TAG_W{1'b0}}) begin
      res = {1'b1, {DATA_LEN{1'b0}}};
    end else if (lsb_en && (lsb_tag == q)) begin
      res = {1'b1, lsb_data};
    end else if (alu_en && (alu_tag == q)) begin
      res = {1'b1, alu_data};
    end else if (stored_ready) begin
      res = {1'b1, stored_data};
    end else begin
      res = {1'b0, {DATA_LEN{1'b0}}};
    end
    return res;
  endfunction

  assign unused_head_pc_s = pc_r[head_r];

  // Admission uses the pre-edge count, so a same-cycle commit never frees a slot early.
  assign alloc_s  = ena_from_dsp && (count_r != DEPTH_C);
  assign commit_s = busy_r[head_r] && ready_r[head_r];

  // Occupancy after this edge.
  always_comb begin
    next_count_s = count_r;
    case ({alloc_s, commit_s})
      2'b10:   next_count_s = count_r + TAG_W'(1);
      2'b01:   next_count_s = count_r - TAG_W'(1);
      default: next_count_s = count_r;
    endcase
  end

  // Per-entry writeback decode; only busy entries accept results.
  always_comb begin
    alu_hit_s = {DEPTH{1'b0}};
    lsb_hit_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      alu_hit_s[i] = ena_from_alu && (rob_id_from_alu == TAG_W'(i + 1)) && busy_r[i];
      lsb_hit_s[i] = ena_from_lsb && (rob_id_from_lsb == TAG_W'(i + 1)) && busy_r[i];
    end
  end

  // Combinational operand readiness and value for both dispatcher queries.
  always_comb begin
    q1_idx_s = ROB_LEN'(Q1_from_dsp - TAG_W'(1));
    q2_idx_s = ROB_LEN'(Q2_from_dsp - TAG_W'(1));
    {Q1_ready_to_dsp, V1_to_dsp} = resolve_query(Q1_from_dsp, ready_r[q1_idx_s], data_r[q1_idx_s],
                                                 ena_from_alu, rob_id_from_alu, data_from_alu,
                                                 ena_from_lsb, rob_id_from_lsb, data_from_lsb);
    {Q2_ready_to_dsp, V2_to_dsp} = resolve_query(Q2_from_dsp, ready_r[q2_idx_s], data_r[q2_idx_s],
                                                 ena_from_alu, rob_id_from_alu, data_from_alu,
                                                 ena_from_lsb, rob_id_from_lsb, data_from_lsb);
  end

  // Pointers, occupancy, allocation tag, commit port and almost-full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r        <= {ROB_LEN{1'b0}};
      tail_r        <= {ROB_LEN{1'b0}};
      count_r       <= {TAG_W{1'b0}};
      rob_id_to_dsp <= {TAG_W{1'b0}};
      ena_to_reg    <= 1'b0;
      rd_to_reg     <= {REG_LEN{1'b0}};
      Q_to_reg      <= {TAG_W{1'b0}};
      V_to_reg      <= {DATA_LEN{1'b0}};
      full_to_dsp   <= 1'b0;
    end else if (rdy) begin
      if (alloc_s) begin
        tail_r        <= tail_r + ROB_LEN'(1);
        rob_id_to_dsp <= {1'b0, tail_r} + TAG_W'(1);
      end
      if (commit_s) begin
        head_r     <= head_r + ROB_LEN'(1);
        ena_to_reg <= 1'b1;
        rd_to_reg  <= rd_r[head_r];
        Q_to_reg   <= {1'b0, head_r} + TAG_W'(1);
        V_to_reg   <= data_r[head_r];
      end else begin
        ena_to_reg <= 1'b0;
      end
      count_r     <= next_count_s;
      // Raised one entry early so a request already in flight still fits.
      full_to_dsp <= (next_count_s >= ALMOST_C);
    end
  end

  // Entry storage: commit clears, allocation fills, writeback sets ready (LSB first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r  <= {DEPTH{1'b0}};
      ready_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= {REG_LEN{1'b0}};
        data_r[i] <= {DATA_LEN{1'b0}};
        pc_r[i]   <= {ADDR_LEN{1'b0}};
      end
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_s && (head_r == ROB_LEN'(i))) begin
          busy_r[i]  <= 1'b0;
          ready_r[i] <= 1'b0;
        end else if (alloc_s && (tail_r == ROB_LEN'(i))) begin
          busy_r[i]  <= 1'b1;
          ready_r[i] <= 1'b0;
          rd_r[i]    <= rd_from_dsp;
          data_r[i]  <= data_from_dsp;
          pc_r[i]    <= pc_from_dsp;
        end else if (lsb_hit_s[i]) begin
          data_r[i]  <= data_from_lsb;
          ready_r[i] <= 1'b1;
        end else if (alu_hit_s[i]) begin
          data_r[i]  <= data_from_alu;
          ready_r[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_alloc_responder.sv
module tb_rob_alloc_responder;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ena_from_dsp;
  logic [4:0]  rd_from_dsp;
  logic [31:0] data_from_dsp, pc_from_dsp;
  logic [4:0]  rob_id_to_dsp;
  logic [4:0]  Q1_from_dsp, Q2_from_dsp;
  logic        Q1_ready_to_dsp, Q2_ready_to_dsp;
  logic [31:0] V1_to_dsp, V2_to_dsp;
  logic        ena_from_alu, ena_from_lsb;
  logic [4:0]  rob_id_from_alu, rob_id_from_lsb;
  logic [31:0] data_from_alu, data_from_lsb;
  logic        ena_to_reg;
  logic [4:0]  rd_to_reg, Q_to_reg;
  logic [31:0] V_to_reg;
  logic        full_to_dsp;

  int checks = 0;
  int errors = 0;

  rob_alloc_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
    .data_from_dsp(data_from_dsp), .pc_from_dsp(pc_from_dsp),
    .rob_id_to_dsp(rob_id_to_dsp),
    .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
    .Q1_ready_to_dsp(Q1_ready_to_dsp), .Q2_ready_to_dsp(Q2_ready_to_dsp),
    .V1_to_dsp(V1_to_dsp), .V2_to_dsp(V2_to_dsp),
    .ena_from_alu(ena_from_alu), .rob_id_from_alu(rob_id_from_alu), .data_from_alu(data_from_alu),
    .ena_from_lsb(ena_from_lsb), .rob_id_from_lsb(rob_id_from_lsb), .data_from_lsb(data_from_lsb),
    .ena_to_reg(ena_to_reg), .rd_to_reg(rd_to_reg), .Q_to_reg(Q_to_reg),
    .V_to_reg(V_to_reg), .full_to_dsp(full_to_dsp)
  );

  always #5 clk = ~clk;

  // Reference model: entries indexed by tag, program order kept as a queue of tags.
  bit          m_busy  [1:16];
  bit          m_ready [1:16];
  logic [4:0]  m_rd    [1:16];
  logic [31:0] m_data  [1:16];
  int          m_order [$];
  int          m_next;
  logic [4:0]  m_id, m_rdo, m_q;
  logic [31:0] m_v;
  bit          m_ena, m_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 1; t <= 16; t++) begin
      m_busy[t] = 0; m_ready[t] = 0; m_rd[t] = 5'd0; m_data[t] = 32'd0;
    end
    m_order.delete();
    m_next = 1;
    m_id = 5'd0; m_rdo = 5'd0; m_q = 5'd0; m_v = 32'd0; m_ena = 0; m_full = 0;
  endtask

  task automatic model_step();
    int ct;
    bit do_alloc;
    if (!rdy) return;
    ct = 0;
    if (m_order.size() > 0 && m_ready[m_order[0]]) ct = m_order[0];
    do_alloc = ena_from_dsp && (m_order.size() < 16);
    if (ct != 0) begin
      m_ena = 1; m_rdo = m_rd[ct]; m_q = 5'(ct); m_v = m_data[ct];
    end else begin
      m_ena = 0;
    end
    if (ena_from_alu && rob_id_from_alu != 5'd0 && m_busy[rob_id_from_alu]) begin
      m_data[rob_id_from_alu] = data_from_alu; m_ready[rob_id_from_alu] = 1;
    end
    if (ena_from_lsb && rob_id_from_lsb != 5'd0 && m_busy[rob_id_from_lsb]) begin
      m_data[rob_id_from_lsb] = data_from_lsb; m_ready[rob_id_from_lsb] = 1;
    end
    if (ct != 0) begin
      m_busy[ct] = 0; m_ready[ct] = 0; void'(m_order.pop_front());
    end
    if (do_alloc) begin
      m_busy[m_next] = 1; m_ready[m_next] = 0;
      m_rd[m_next] = rd_from_dsp; m_data[m_next] = data_from_dsp;
      m_order.push_back(m_next);
      m_id = 5'(m_next);
      m_next = (m_next % 16) + 1;
    end
    m_full = (m_order.size() >= 15);
  endtask

  task automatic model_query(input logic [4:0] q, output bit r, output logic [31:0] v);
    if (q == 5'd0) begin r = 1; v = 32'd0; end
    else if (ena_from_lsb && rob_id_from_lsb == q) begin r = 1; v = data_from_lsb; end
    else if (ena_from_alu && rob_id_from_alu == q) begin r = 1; v = data_from_alu; end
    else if (m_ready[q]) begin r = 1; v = m_data[q]; end
    else begin r = 0; v = 32'd0; end
  endtask

  task automatic check_query();
    bit r; logic [31:0] v;
    model_query(Q1_from_dsp, r, v);
    chk("q1_ready", Q1_ready_to_dsp, r); chk("v1", V1_to_dsp, v);
    model_query(Q2_from_dsp, r, v);
    chk("q2_ready", Q2_ready_to_dsp, r); chk("v2", V2_to_dsp, v);
  endtask

  task automatic check_regs();
    chk("rob_id", rob_id_to_dsp, m_id);
    chk("ena_to_reg", ena_to_reg, m_ena);
    chk("rd_to_reg", rd_to_reg, m_rdo);
    chk("Q_to_reg", Q_to_reg, m_q);
    chk("V_to_reg", V_to_reg, m_v);
    chk("full", full_to_dsp, m_full);
  endtask

  // Inputs are driven just after a falling edge; tick checks queries pre-edge
  // and registered outputs at the next falling edge.
  task automatic tick();
    #1 check_query();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic clear_inputs();
    rdy = 1'b1;
    ena_from_dsp = 1'b0; rd_from_dsp = 5'd0; data_from_dsp = 32'd0; pc_from_dsp = 32'd0;
    Q1_from_dsp = 5'd0; Q2_from_dsp = 5'd0;
    ena_from_alu = 1'b0; rob_id_from_alu = 5'd0; data_from_alu = 32'd0;
    ena_from_lsb = 1'b0; rob_id_from_lsb = 5'd0; data_from_lsb = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pick_tag(output logic [4:0] t);
    if (m_order.size() > 0 && $urandom_range(0, 3) != 0)
      t = 5'(m_order[$urandom_range(0, m_order.size() - 1)]);
    else
      t = 5'($urandom_range(0, 16));
  endtask

  typedef struct {
    logic        ena; logic [4:0] rd; logic [31:0] data; logic [31:0] pc;
    logic        alu_en; logic [4:0] alu_id; logic [31:0] alu_d;
    logic        lsb_en; logic [4:0] lsb_id; logic [31:0] lsb_d;
    logic [4:0]  q1, q2;
    logic        e_q1r; logic [31:0] e_v1; logic e_q2r; logic [31:0] e_v2;
    logic [4:0]  e_id; logic e_ena; logic [4:0] e_rd; logic [4:0] e_q; logic [31:0] e_v; logic e_full;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // inputs | pre-edge query expectations | post-edge registered expectations
    vecs[0] = '{1, 1, 'hD1, 'h0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0,     1, 0,     1, 0, 0, 0, 0,     0};
    vecs[1] = '{1, 2, 'hD2, 'h4, 0, 0, 0,     0, 0, 0, 1, 0, 0, 0,     1, 0,     2, 0, 0, 0, 0,     0};
    vecs[2] = '{1, 3, 'hD3, 'h8, 0, 0, 0,     0, 0, 0, 0, 0, 1, 0,     1, 0,     3, 0, 0, 0, 0,     0};
    vecs[3] = '{0, 0, 0,    0,   1, 2, 'hAB,  0, 0, 0, 2, 1, 1, 'hAB,  0, 0,     3, 0, 0, 0, 0,     0};
    vecs[4] = '{0, 0, 0,    0,   1, 1, 'h11,  0, 0, 0, 2, 1, 1, 'hAB,  1, 'h11,  3, 0, 0, 0, 0,     0};
    vecs[5] = '{0, 0, 0,    0,   0, 0, 0,     0, 0, 0, 3, 1, 0, 0,     1, 'h11,  3, 1, 1, 1, 'h11,  0};
    vecs[6] = '{0, 0, 0,    0,   0, 0, 0,     0, 0, 0, 0, 2, 1, 0,     1, 'hAB,  3, 1, 2, 2, 'hAB,  0};
    vecs[7] = '{0, 0, 0,    0,   0, 0, 0,     0, 0, 0, 2, 3, 0, 0,     0, 0,     3, 0, 2, 2, 'hAB,  0};

    rst = 1'b0;
    clear_inputs();
    model_reset();

    // ---- reset values + directed table ----
    do_reset();
    check_regs();
    foreach (vecs[i]) begin
      ena_from_dsp = vecs[i].ena; rd_from_dsp = vecs[i].rd;
      data_from_dsp = vecs[i].data; pc_from_dsp = vecs[i].pc;
      ena_from_alu = vecs[i].alu_en; rob_id_from_alu = vecs[i].alu_id; data_from_alu = vecs[i].alu_d;
      ena_from_lsb = vecs[i].lsb_en; rob_id_from_lsb = vecs[i].lsb_id; data_from_lsb = vecs[i].lsb_d;
      Q1_from_dsp = vecs[i].q1; Q2_from_dsp = vecs[i].q2;
      #1;
      chk($sformatf("vec%0d_q1r", i), Q1_ready_to_dsp, vecs[i].e_q1r);
      chk($sformatf("vec%0d_v1", i), V1_to_dsp, vecs[i].e_v1);
      chk($sformatf("vec%0d_q2r", i), Q2_ready_to_dsp, vecs[i].e_q2r);
      chk($sformatf("vec%0d_v2", i), V2_to_dsp, vecs[i].e_v2);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_id", i), rob_id_to_dsp, vecs[i].e_id);
      chk($sformatf("vec%0d_ena", i), ena_to_reg, vecs[i].e_ena);
      chk($sformatf("vec%0d_rd", i), rd_to_reg, vecs[i].e_rd);
      chk($sformatf("vec%0d_q", i), Q_to_reg, vecs[i].e_q);
      chk($sformatf("vec%0d_v", i), V_to_reg, vecs[i].e_v);
      chk($sformatf("vec%0d_full", i), full_to_dsp, vecs[i].e_full);
    end

    // ---- fill to capacity, drop on full, full-with-commit, rdy freeze ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ena_from_dsp = 1'b1; rd_from_dsp = 5'(i + 1); data_from_dsp = 32'h100 + 32'(i);
      pc_from_dsp = 32'(4 * i);
      tick();
      if (i == 13) chk("full_at_14", full_to_dsp, 1'b0);
      if (i == 14) begin chk("full_at_15", full_to_dsp, 1'b1); chk("id_15", rob_id_to_dsp, 5'd15); end
      if (i == 15) chk("id_16", rob_id_to_dsp, 5'd16);
      if (i == 16) chk("id_drop_17", rob_id_to_dsp, 5'd16);
    end
    ena_from_alu = 1'b1; rob_id_from_alu = 5'd1; data_from_alu = 32'h55;
    tick();
    ena_from_alu = 1'b0;
    tick();
    chk("full_commit_ena", ena_to_reg, 1'b1);
    chk("full_commit_q", Q_to_reg, 5'd1);
    chk("full_commit_v", V_to_reg, 32'h55);
    chk("full_commit_no_admit", rob_id_to_dsp, 5'd16);
    rdy = 1'b0;
    tick();
    chk("rdy0_ena_hold", ena_to_reg, 1'b1);
    chk("rdy0_id_hold", rob_id_to_dsp, 5'd16);
    rdy = 1'b1;
    tick();
    chk("wrap_id", rob_id_to_dsp, 5'd1);
    chk("wrap_full", full_to_dsp, 1'b1);
    ena_from_dsp = 1'b0;
    tick();

    // ---- both buses write the same tag ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ena_from_dsp = 1'b1; rd_from_dsp = 5'(i + 1); data_from_dsp = 32'hC0 + 32'(i);
      tick();
    end
    ena_from_dsp = 1'b0;
    ena_from_alu = 1'b1; rob_id_from_alu = 5'd5; data_from_alu = 32'h1;
    ena_from_lsb = 1'b1; rob_id_from_lsb = 5'd5; data_from_lsb = 32'h2;
    Q2_from_dsp = 5'd5;
    #1 chk("same_tag_bypass", V2_to_dsp, 32'h2);
    tick();
    ena_from_alu = 1'b0; ena_from_lsb = 1'b0;
    #1 chk("same_tag_stored_rdy", Q2_ready_to_dsp, 1'b1);
    chk("same_tag_stored_v", V2_to_dsp, 32'h2);
    tick();

    // ---- asynchronous reset mid-cycle ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ena_from_dsp = 1'b1; rd_from_dsp = 5'(i + 1); data_from_dsp = 32'hE0 + 32'(i);
      tick();
    end
    ena_from_dsp = 1'b0;
    ena_from_alu = 1'b1; rob_id_from_alu = 5'd1; data_from_alu = 32'h77;
    tick();
    ena_from_alu = 1'b0; Q1_from_dsp = 5'd2;
    tick();
    chk("pre_rst_ena", ena_to_reg, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_id", rob_id_to_dsp, 5'd0);
    chk("arst_ena", ena_to_reg, 1'b0);
    chk("arst_rd", rd_to_reg, 5'd0);
    chk("arst_q", Q_to_reg, 5'd0);
    chk("arst_v", V_to_reg, 32'd0);
    chk("arst_full", full_to_dsp, 1'b0);
    chk("arst_q1r", Q1_ready_to_dsp, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    ena_from_dsp = 1'b1; rd_from_dsp = 5'd9; data_from_dsp = 32'h9;
    tick();
    chk("post_rst_id", rob_id_to_dsp, 5'd1);
    ena_from_dsp = 1'b0;
    tick();

    // ---- randomized traffic against the reference model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      ena_from_dsp = ($urandom_range(0, 9) < 6);
      rd_from_dsp = 5'($urandom); data_from_dsp = $urandom; pc_from_dsp = $urandom;
      ena_from_alu = ($urandom_range(0, 2) != 0); pick_tag(rob_id_from_alu); data_from_alu = $urandom;
      ena_from_lsb = ($urandom_range(0, 2) != 0); pick_tag(rob_id_from_lsb); data_from_lsb = $urandom;
      if ($urandom_range(0, 7) == 0) rob_id_from_lsb = rob_id_from_alu;
      pick_tag(Q1_from_dsp);
      pick_tag(Q2_from_dsp);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_alloc_responder.md
Name: rob_alloc_responder

Overview:
Reorder buffer that answers the dispatcher's allocation and operand-readiness protocol. It allocates entries in program order, returns the ROB tag on the cycle after the request, and answers Q1/Q2 readiness (with value) queries combinationally. It captures results from the ALU and LSB broadcast buses and retires ready head entries in order to the register file.

Parameters:
ROB_LEN, 4, index width; depth DEPTH = 2^ROB_LEN entries; tags are ROB_LEN+1 bits
DATA_LEN, 32, result width
ADDR_LEN, 32, pc width
REG_LEN, 5, architectural register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global ready; 0 freezes all state, registered outputs hold
ena_from_dsp  in  1  allocation request
rd_from_dsp  in  REG_LEN  destination register of allocated instruction
data_from_dsp  in  DATA_LEN  initial entry data (stored, overwritten on writeback)
pc_from_dsp  in  ADDR_LEN  instruction pc
rob_id_to_dsp  out  ROB_LEN+1  registered tag of last allocated entry
Q1_from_dsp  in  ROB_LEN+1  tag queried for operand 1 (0 = no dependency)
Q2_from_dsp  in  ROB_LEN+1  tag queried for operand 2
Q1_ready_to_dsp  out  1  combinational readiness for Q1
Q2_ready_to_dsp  out  1  combinational readiness for Q2
V1_to_dsp  out  DATA_LEN  combinational value for Q1 (0 when not ready or Q1=0)
V2_to_dsp  out  DATA_LEN  combinational value for Q2
ena_from_alu, rob_id_from_alu, data_from_alu  in  1 / ROB_LEN+1 / DATA_LEN  ALU writeback
ena_from_lsb, rob_id_from_lsb, data_from_lsb  in  1 / ROB_LEN+1 / DATA_LEN  LSB writeback
ena_to_reg  out  1  commit strobe, registered, one-cycle pulse
rd_to_reg  out  REG_LEN  committed destination
Q_to_reg  out  ROB_LEN+1  tag of committed entry (regfile clears Q only if it still matches)
V_to_reg  out  DATA_LEN  committed value
full_to_dsp  out  1  registered almost-full flag

Behaviour:
- Tag encoding: entry index i maps to tag i+1; tag 0 means "no dependency". Storage per entry: busy, ready, rd, data, pc.
- Reset (rst=0, async): head=tail=0, count=0, all busy/ready cleared; rob_id_to_dsp=0, ena_to_reg=0, rd_to_reg=0, Q_to_reg=0, V_to_reg=0, full_to_dsp=0.
- rdy=0: no state change; ena_to_reg holds its value.
- Allocation: on an edge with ena_from_dsp=1 and count<DEPTH, write entry[tail] (busy=1, ready=0, rd, data, pc); rob_id_to_dsp <= tail+1; tail wraps modulo DEPTH. Latency: tag visible the cycle after the request. Request while count==DEPTH is dropped; rob_id_to_dsp holds.
- full_to_dsp <= (next count >= DEPTH-1). This gives one cycle of margin for the dispatcher's registered request.
- Writeback: for each bus with ena=1 and nonzero tag whose entry is busy, set data and ready=1. Writes to non-busy entries are ignored. Both buses may fire in the same cycle on different tags. Same tag on both buses: the LSB bus wins.
- Query: Qx_ready = (Qx==0) | entry ready | matching ALU/LSB writeback this cycle (bypass, LSB priority). Vx is the bypassed or stored data when ready and Qx≠0, else 0.
- Commit: when entry[head] is busy and ready, on the edge: ena_to_reg<=1, rd_to_reg, Q_to_reg=head+1, V_to_reg=data; clear busy/ready; head wraps. Otherwise ena_to_reg<=0. At most one commit per cycle. An entry written back in cycle N commits at edge N+1 at the earliest; no same-edge writeback-commit bypass.
- Simultaneous alloc and commit: count unchanged; both performed. When full, a simultaneous commit does not admit that cycle's request (full check uses pre-edge count).
- rd=0 entries commit normally; the regfile ignores them.
- Reset asserted mid-operation discards all entries immediately.

Test Plan:
- Reset then 3 allocations (pc 0x0,0x4,0x8; rd 1,2,3) -> rob_id_to_dsp = 1,2,3 on cycles after each request; full_to_dsp=0.
- ALU writeback tag 2 data 0xAB while Q1_from_dsp=2 -> Q1_ready_to_dsp=1, V1_to_dsp=0xAB same cycle; no commit (head tag 1 not ready).
- Writeback tag 1 data 0x11 -> next edge ena_to_reg=1, rd=1, Q=1, V=0x11; following edge commits tag 2 (rd=2, V=0xAB); then ena_to_reg=0.
- Allocate 15 entries with ROB_LEN=4 -> full_to_dsp=1; 16th allocation accepted (tag 16), 17th dropped (rob_id_to_dsp stays 16).
- Same cycle: ALU and LSB both write tag 5 (0x1 / 0x2) -> stored 0x2; query Q2=5 returns 0x2.
- Drive rst=0 asynchronously between edges with 4 busy entries -> outputs zero immediately; next allocation returns tag 1.
